// File: rtl/fetch_unit.sv
// Instruction fetch stage: tracks the fetch PC, issues single-outstanding imem
// requests and buffers returned words with their PCs in a prefetch queue.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_next;
  logic [31:0]     r_imem_addr;
  logic [31:0]     w_addr_next;
  logic [31:0]     w_pc_inc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            w_xfer;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     r_q_pc   [DEPTH];
  logic [31:0]     r_q_word [DEPTH];

  // Handshakes: an imem transfer is imem_req && imem_ack in the same cycle;
  // a decode pop is instr_valid && instr_ready in the same cycle.
  assign w_xfer       = (r_state != ST_IDLE) && imem_ack;
  assign w_push       = w_xfer && (r_state == ST_REQ);
  assign w_pop        = (r_count != '0) && instr_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_pc_inc     = r_fetch_pc + 32'd4;

  assign imem_req    = (r_state != ST_IDLE);
  assign imem_addr   = r_imem_addr;
  assign instr       = r_q_word[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];
  assign instr_valid = (r_count != '0);
  assign dbg_state   = r_state;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = r_imem_addr;
    if (redirect) begin
      w_fetch_pc_next = redirect_pc;
      // A still-pending request cannot be cancelled; its response must be eaten.
      if ((r_state != ST_IDLE) && !w_xfer) begin
        w_state_next = ST_DROP;
      end else begin
        w_state_next = ST_REQ;
        w_addr_next  = redirect_pc;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_count < CW'(DEPTH)) begin
            w_state_next = ST_REQ;
            w_addr_next  = r_fetch_pc;
          end
        end
        ST_REQ: begin
          if (w_xfer) begin
            w_fetch_pc_next = w_pc_inc;
            if (w_count_next < CW'(DEPTH)) begin
              w_addr_next = w_pc_inc;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (w_xfer) begin
            w_state_next = ST_REQ;
            w_addr_next  = r_fetch_pc;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_imem_addr <= w_addr_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= w_count_next;
      end
    end
  end

  // Queue storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !redirect) begin
      r_q_pc[r_wr_ptr]   <= r_imem_addr;
      r_q_word[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill, streaming, backpressure, redirect cases,
// mid-stream reset and PC wrap-around, against a latency-configurable memory.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One clock; memory acks a request in its lat-th visible cycle.
  task automatic cyc();
    logic xfer;
    xfer = imem_req && imem_ack;
    @(posedge clk);
    #1;
    if (!imem_req) wait_cnt = 0;
    else if (xfer) wait_cnt = 1;
    else wait_cnt = wait_cnt + 1;
    imem_ack   = imem_req && (wait_cnt >= lat);
    imem_rdata = imem_addr ^ K;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    n_tests++; if (imem_req !== 1'b0) begin $display("FAIL reset_req act=%b exp=0", imem_req); n_fail++; end
    n_tests++; if (imem_addr !== 32'h0) begin $display("FAIL reset_addr act=%h exp=0", imem_addr); n_fail++; end
    n_tests++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid act=%b exp=0", instr_valid); n_fail++; end
    n_tests++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state act=%0d exp=0", dbg_state); n_fail++; end
    reset = 1'b0;
    cyc();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      $display("FAIL first_req act=%b/%h exp=1/00000000", imem_req, imem_addr); n_fail++; end
  endtask

  task automatic test_fill();
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        $display("FAIL fill_addr[%0d] act=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i)); n_fail++; end
      n_tests++; if (instr_valid !== (i > 0)) begin
        $display("FAIL fill_valid[%0d] act=%b exp=%b", i, instr_valid, (i > 0)); n_fail++; end
    end
    cyc();
    n_tests++; if (imem_req !== 1'b0) begin $display("FAIL fill_req_drop act=%b exp=0", imem_req); n_fail++; end
    n_tests++; if (instr_pc !== 32'h0 || instr !== K) begin
      $display("FAIL fill_head act=%h/%h exp=00000000/%h", instr_pc, instr, K); n_fail++; end
  endtask

  task automatic test_backpressure();
    cyc();
    n_tests++; if (imem_req !== 1'b0) begin $display("FAIL bp_full_idle act=%b exp=0", imem_req); n_fail++; end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    n_tests++; if (instr_pc !== 32'h4 || imem_req !== 1'b0) begin
      $display("FAIL bp_pop act=%h/%b exp=00000004/0", instr_pc, imem_req); n_fail++; end
    cyc();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      $display("FAIL bp_one_req act=%b/%h exp=1/00000010", imem_req, imem_addr); n_fail++; end
    cyc();
    n_tests++; if (imem_req !== 1'b0) begin $display("FAIL bp_refull act=%b exp=0", imem_req); n_fail++; end
    cyc();
    n_tests++; if (imem_req !== 1'b0) begin $display("FAIL bp_only_one act=%b exp=0", imem_req); n_fail++; end
    lat = 100;
    exp_q = {32'h4, 32'h8, 32'hC, 32'h10};
    instr_ready = 1'b1;
    while (exp_q.size() > 0) begin
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== exp_q[0] || instr !== (exp_q[0] ^ K)) begin
        $display("FAIL bp_order act=%b/%h/%h exp=1/%h/%h", instr_valid, instr_pc, instr, exp_q[0], exp_q[0] ^ K);
        n_fail++; end
      void'(exp_q.pop_front());
      cyc();
    end
    instr_ready = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin $display("FAIL bp_empty act=%b exp=0", instr_valid); n_fail++; end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      $display("FAIL bp_refetch act=%b/%h exp=1/00000014", imem_req, imem_addr); n_fail++; end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    lat = 3;
    n = 0;
    while (n < 20 && !(imem_req === 1'b1 && imem_addr === 32'h8)) begin
      cyc();
      n++;
    end
    n_tests++; if (imem_addr !== 32'h8 || imem_ack !== 1'b0) begin
      $display("FAIL rw_reach8 act=%h/%b exp=00000008/0", imem_addr, imem_ack); n_fail++; end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0 || dbg_state !== 2'd2) begin
      $display("FAIL rw_drop act=%b/%h/%b/%0d exp=1/00000008/0/2", imem_req, imem_addr, instr_valid, dbg_state);
      n_fail++; end
    cyc();
    n_tests++; if (imem_addr !== 32'h8) begin $display("FAIL rw_hold act=%h exp=00000008", imem_addr); n_fail++; end
    cyc();
    n_tests++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      $display("FAIL rw_newreq act=%h/%b/%b exp=00000100/1/0", imem_addr, imem_req, instr_valid); n_fail++; end
    n = 0;
    while (n < 10 && instr_valid !== 1'b1) begin
      cyc();
      n++;
    end
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ K)) begin
      $display("FAIL rw_first act=%b/%h/%h exp=1/00000100/%h", instr_valid, instr_pc, instr, 32'h100 ^ K);
      n_fail++; end
  endtask

  task automatic test_streaming();
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    cyc();
    n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      $display("FAIL st_start act=%b/%b exp=0/1", instr_valid, imem_req); n_fail++; end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== (32'(4 * i) ^ K)) begin
        $display("FAIL st_word[%0d] act=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr_pc, instr,
                 32'(4 * i), 32'(4 * i) ^ K); n_fail++; end
    end
  endtask

  task automatic test_simultaneous();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 || dbg_state !== 2'd1) begin
      $display("FAIL sim_redirect act=%b/%b/%h/%0d exp=0/1/00000040/1", instr_valid, imem_req, imem_addr, dbg_state);
      n_fail++; end
    cyc();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== (32'h40 ^ K)) begin
      $display("FAIL sim_first act=%b/%h/%h exp=1/00000040/%h", instr_valid, instr_pc, instr, 32'h40 ^ K);
      n_fail++; end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 1;
    cyc();
    cyc();
    cyc();
    n_tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      $display("FAIL rm_pre act=%b/%b/%h exp=1/1/00000008", instr_valid, imem_req, imem_addr); n_fail++; end
    reset = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL rm_async act=%b/%h/%b/%0d exp=0/00000000/0/0", imem_req, imem_addr, instr_valid, dbg_state);
      n_fail++; end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    lat = 1;
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    cyc();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC || instr_valid !== 1'b0) begin
      $display("FAIL wrap_req act=%b/%h/%b exp=1/fffffffc/0", imem_req, imem_addr, instr_valid); n_fail++; end
    cyc();
    n_tests++; if (imem_addr !== 32'h0) begin $display("FAIL wrap_next act=%h exp=00000000", imem_addr); n_fail++; end
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFFFFFC || instr !== (32'hFFFFFFFC ^ K)) begin
      $display("FAIL wrap_head act=%b/%h/%h exp=1/fffffffc/%h", instr_valid, instr_pc, instr, 32'hFFFFFFFC ^ K);
      n_fail++; end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_redirect_wait();
    test_streaming();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the data path and supplies its `instr` input. It tracks the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake. Returned words go into a DEPTH-entry prefetch queue together with their PCs. The head of the queue is presented to decode through a valid/ready handshake, and a `redirect` input (taken branch or PC write) flushes the queue and restarts fetch.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0: fetch PC after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  flush queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; word-aligned.
- `imem_req`  out  1  memory request; registered.
- `imem_addr`  out  32  request address; registered, stable while `imem_req` is high.
- `imem_ack`  in  1  completion; a transfer occurs in any cycle with `imem_req && imem_ack`.
- `imem_rdata`  in  32  instruction word; valid in the transfer cycle.
- `instr`  out  32  head-of-queue instruction.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  decode accepts the head; a pop occurs when `instr_valid && instr_ready`.

## Operation
- **State machine:** IDLE (no request), REQ (request for `fetch_pc` outstanding), DROP (stale request outstanding; its response is discarded).
- **Queue:** circular buffer of {pc, word} with rd/wr pointers and a count (0..DEPTH).
  - `count_next` = count + push − pop.
  - Push and pop in the same cycle are both honoured.
- **IDLE:**
  - If `count < DEPTH`: go to REQ, `imem_req`←1, `imem_addr`←`fetch_pc`.
  - Otherwise stay in IDLE.
- **REQ with transfer:**
  - Push {`imem_addr`, `imem_rdata`}.
  - `fetch_pc`←`fetch_pc`+4, with 32-bit wrap-around (32'hFFFFFFFC + 4 = 0).
  - If `count_next < DEPTH`: stay in REQ with `imem_addr`←new `fetch_pc` (back-to-back requests).
  - Otherwise go to IDLE with `imem_req`←0.
- **REQ without transfer:** hold `imem_req` and `imem_addr`.
- **DROP:**
  - `imem_req` and `imem_addr` are held at the stale address until the transfer.
  - On transfer: discard the data (no push) and go to REQ with `imem_addr`←`fetch_pc`.
- **Redirect:** has priority over everything else in the same cycle.
  - count←0 and pointers←0; any pop or push in that cycle is ignored.
  - `fetch_pc`←`redirect_pc`.
  - If state is REQ or DROP and no transfer occurs this cycle: go to / stay in DROP.
  - Otherwise (IDLE, or a transfer this cycle): go to REQ with `imem_addr`←`redirect_pc`.
- The queue can never overflow: a request is issued only when a slot is guaranteed for its response.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, state IDLE, `fetch_pc`=`RESET_PC`, count=0. `instr` and `instr_pc` read the entry at pointer 0; their value is don't-care while `instr_valid`=0.
- **First request:** `imem_req` rises in the first cycle after the first rising edge with `reset` deasserted.
- **Fill latency:** a transfer in cycle t gives `instr_valid`=1 and the word at the head in cycle t+1 (queue previously empty).
- **Throughput:** with `imem_ack` tied high and `instr_ready` high, one instruction per cycle, sustained.
- **Redirect in cycle t:**
  - `instr_valid`=0 in t+1.
  - If not in DROP, `imem_req`=1 with `imem_addr`=`redirect_pc` in t+1.
  - First new instruction visible no earlier than t+2.
- **Reset mid-operation:** immediately returns all state to reset values, including a pending request. The memory side must tolerate an abandoned request.
- **Output paths:** `instr`, `instr_pc` and `instr_valid` are driven directly from registers; no combinational path from `imem_ack` or `redirect` to them.

## Test plan
- **Reset and fill:** reset, `RESET_PC`=0, `imem_ack`=1, `instr_ready`=0 → `imem_addr` steps 0,4,8,12; `instr_valid` rises one cycle after the first ack; `imem_req` drops after the 4th transfer (DEPTH=4); head `instr_pc`=0.
- **Streaming:** `imem_ack`=1, `instr_ready`=1, `imem_rdata`=addr^32'hA5A5A5A5 → one pop per cycle with `instr_pc` 0,4,8,… and matching data; no gaps after the first.
- **Backpressure:**
  - Full queue, `instr_ready` pulsed high for one cycle → exactly one new request issued.
  - Pop order preserved; count never exceeds 4.
- **Redirect during wait:**
  - Memory with 3-cycle ack latency; redirect to 32'h100 while a request to 32'h8 is un-acked → `imem_addr` held at 8 until ack; that word is not pushed.
  - Next request is to 32'h100; first valid `instr_pc`=32'h100.
- **Simultaneous events:** redirect to 32'h40 in the same cycle as a transfer and a pop → queue empty next cycle; no DROP; `imem_addr`=32'h40 with `imem_req`=1 next cycle.
- **Reset mid-stream and wrap:**
  - Assert `reset` while `imem_req`=1 and count=2 → all outputs at reset values immediately.
  - Separately, redirect to 32'hFFFFFFFC → the next fetch address is 32'h0.
